// File: rtl/mau_load_swc.sv
// mau_load_swc: load engine of the memory-access unit.
// Accepts one load request from the execute stage, computes the effective
// address, performs a single AHB-Lite read, then aligns and extends the
// returned lane and writes it to the register file.
// Ports:
//   hclk, hrst               clock, asynchronous active-high reset
//   exu_load_*               load request (level valid, held until consumed)
//   haddr/htrans/hsize/hwrite AHB-Lite address phase (read only)
//   hrdata/hready/hresp      AHB-Lite data phase response
//   reg_waddr/wen/wdata      register file write port (wen is a 1-cycle pulse)
//   mau_load_busy/done/err   status; err is sticky until the next accept
//   mau_load_err_addr        effective address of the last faulting load
module mau_load_swc #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              exu_load_en,
  input  logic [4:0]        exu_load_rd,
  input  logic [ADDR_W-1:0] exu_load_base_addr,
  input  logic [ADDR_W-1:0] exu_load_offset,
  input  logic              exu_load_sext,
  input  logic [1:0]        exu_load_size,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic              hwrite,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic [4:0]        reg_waddr,
  output logic              reg_wen,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mau_load_busy,
  output logic              mau_load_done,
  output logic              mau_load_err,
  output logic [ADDR_W-1:0] mau_load_err_addr
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_consumed;
  logic              r_sext;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_haddr;
  logic [1:0]        r_htrans;
  logic [2:0]        r_hsize;
  logic [4:0]        r_reg_waddr;
  logic              r_reg_wen;
  logic [DATA_W-1:0] r_reg_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_accept;
  logic [ADDR_W-1:0] w_ea;
  logic [1:0]        w_size_m1;
  logic              w_chk_err;
  logic              w_bus_done;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_lane;

  logic [ADDR_W-1:0] w_haddr_nxt;
  logic [1:0]        w_htrans_nxt;
  logic [2:0]        w_hsize_nxt;
  logic [4:0]        w_reg_waddr_nxt;
  logic              w_reg_wen_nxt;
  logic [DATA_W-1:0] w_reg_wdata_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic [ADDR_W-1:0] w_err_addr_nxt;

  // Request decode; the consumed flag keeps a held request from re-issuing.
  assign w_accept   = (r_state == S_IDLE) && exu_load_en && !r_consumed;
  assign w_ea       = exu_load_base_addr + exu_load_offset;
  assign w_size_m1  = exu_load_size - 2'd1;
  assign w_chk_err  = (exu_load_size == 2'd0) ||
                      ((exu_load_size == 2'd2) && w_ea[0]) ||
                      ((exu_load_size == 2'd3) && (w_ea[1:0] != 2'b00));
  assign w_bus_done = (r_state == S_DATA) && hready;

  // Lane select uses the low address bits still held on haddr.
  assign w_byte = 8'(hrdata >> {r_haddr[1:0], 3'b000});
  assign w_half = 16'(hrdata >> {r_haddr[1], 4'b0000});

  always_comb begin
    w_lane = hrdata;
    case (r_size)
      2'd1:    w_lane = {{(DATA_W-8){r_sext & w_byte[7]}}, w_byte};
      2'd2:    w_lane = {{(DATA_W-16){r_sext & w_half[15]}}, w_half};
      default: w_lane = hrdata;
    endcase
  end

  // State register.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_chk_err ? S_WB : S_ADDR;
      S_ADDR: if (hready)   w_state_nxt = S_DATA;
      S_DATA: if (hready)   w_state_nxt = S_WB;
      S_WB:                 w_state_nxt = S_IDLE;
      default:              w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_haddr_nxt     = r_haddr;
    w_htrans_nxt    = HTRANS_IDLE;
    w_hsize_nxt     = r_hsize;
    w_reg_waddr_nxt = r_reg_waddr;
    w_reg_wen_nxt   = 1'b0;
    w_reg_wdata_nxt = r_reg_wdata;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_done_nxt      = (w_state_nxt == S_WB);
    w_err_nxt       = r_err;
    w_err_addr_nxt  = r_err_addr;

    if (w_accept) begin
      w_reg_waddr_nxt = exu_load_rd;
      w_err_nxt       = w_chk_err;
      if (w_chk_err) begin
        w_err_addr_nxt = w_ea;
      end else begin
        w_haddr_nxt = w_ea;
        w_hsize_nxt = {1'b0, w_size_m1};
      end
    end

    if (w_state_nxt == S_ADDR) w_htrans_nxt = HTRANS_NONSEQ;

    if (w_bus_done) begin
      if (hresp) begin
        w_err_nxt      = 1'b1;
        w_err_addr_nxt = r_haddr;
      end else begin
        w_reg_wdata_nxt = w_lane;
        w_reg_wen_nxt   = (r_reg_waddr != 5'd0);
      end
    end
  end

  // Output and request-capture registers.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_consumed  <= 1'b0;
      r_sext      <= 1'b0;
      r_size      <= 2'd0;
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hsize     <= 3'd0;
      r_reg_waddr <= 5'd0;
      r_reg_wen   <= 1'b0;
      r_reg_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_consumed <= 1'b1;
        r_sext     <= exu_load_sext;
        r_size     <= exu_load_size;
      end else if (!exu_load_en) begin
        r_consumed <= 1'b0;
      end
      r_haddr     <= w_haddr_nxt;
      r_htrans    <= w_htrans_nxt;
      r_hsize     <= w_hsize_nxt;
      r_reg_waddr <= w_reg_waddr_nxt;
      r_reg_wen   <= w_reg_wen_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_addr  <= w_err_addr_nxt;
    end
  end

  assign haddr             = r_haddr;
  assign htrans            = r_htrans;
  assign hsize             = r_hsize;
  assign hwrite            = 1'b0;
  assign reg_waddr         = r_reg_waddr;
  assign reg_wen           = r_reg_wen;
  assign reg_wdata         = r_reg_wdata;
  assign mau_load_busy     = r_busy;
  assign mau_load_done     = r_done;
  assign mau_load_err      = r_err;
  assign mau_load_err_addr = r_err_addr;

endmodule

// File: tb/tb_mau_load_swc.sv
// Testbench for mau_load_swc: directed scenarios plus randomized loads,
// each cycle compared against expectations derived from the load rules.
module tb_mau_load_swc;

  logic        hclk = 1'b0;
  logic        hrst;
  logic        exu_load_en;
  logic [4:0]  exu_load_rd;
  logic [31:0] exu_load_base_addr;
  logic [31:0] exu_load_offset;
  logic        exu_load_sext;
  logic [1:0]  exu_load_size;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [4:0]  reg_waddr;
  logic        reg_wen;
  logic [31:0] reg_wdata;
  logic        mau_load_busy;
  logic        mau_load_done;
  logic        mau_load_err;
  logic [31:0] mau_load_err_addr;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference status: sticky error flag and last faulting address.
  logic        m_err;
  logic [31:0] m_err_addr;

  mau_load_swc #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk               (hclk),
    .hrst               (hrst),
    .exu_load_en        (exu_load_en),
    .exu_load_rd        (exu_load_rd),
    .exu_load_base_addr (exu_load_base_addr),
    .exu_load_offset    (exu_load_offset),
    .exu_load_sext      (exu_load_sext),
    .exu_load_size      (exu_load_size),
    .haddr              (haddr),
    .htrans             (htrans),
    .hsize              (hsize),
    .hwrite             (hwrite),
    .hrdata             (hrdata),
    .hready             (hready),
    .hresp              (hresp),
    .reg_waddr          (reg_waddr),
    .reg_wen            (reg_wen),
    .reg_wdata          (reg_wdata),
    .mau_load_busy      (mau_load_busy),
    .mau_load_done      (mau_load_done),
    .mau_load_err       (mau_load_err),
    .mau_load_err_addr  (mau_load_err_addr)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_haddr"},    haddr, 32'h0);
    check({pfx, "_htrans"},   32'(htrans), 32'h0);
    check({pfx, "_hsize"},    32'(hsize), 32'h0);
    check({pfx, "_hwrite"},   32'(hwrite), 32'h0);
    check({pfx, "_waddr"},    32'(reg_waddr), 32'h0);
    check({pfx, "_wen"},      32'(reg_wen), 32'h0);
    check({pfx, "_wdata"},    reg_wdata, 32'h0);
    check({pfx, "_busy"},     32'(mau_load_busy), 32'h0);
    check({pfx, "_done"},     32'(mau_load_done), 32'h0);
    check({pfx, "_err"},      32'(mau_load_err), 32'h0);
    check({pfx, "_err_addr"}, mau_load_err_addr, 32'h0);
  endtask

  // One complete load. Entered and left just after a rising edge.
  // aw/dw: wait states in address/data phase. hold: keep exu_load_en high
  // through the transaction and for idle_cyc cycles after it.
  task automatic run_load(input logic [4:0] rd, input logic [31:0] base,
                          input logic [31:0] off, input logic sext,
                          input logic [1:0] size, input int aw, input int dw,
                          input logic [31:0] rdata, input logic resp,
                          input logic hold, input int idle_cyc);
    logic [31:0] ea;
    logic [31:0] exp_val;
    logic        chk_err;
    logic        exp_wen;
    int          sh;

    ea = base + off;
    chk_err = (size == 2'd0) || (size == 2'd2 && (ea % 2) != 0) ||
              (size == 2'd3 && (ea % 4) != 0);
    case (size)
      2'd1: begin
        sh = 8 * int'(ea % 4);
        exp_val = (rdata >> sh) & 32'hFF;
        if (sext && exp_val >= 32'h80) exp_val = exp_val | 32'hFFFF_FF00;
      end
      2'd2: begin
        sh = 16 * int'((ea / 2) % 2);
        exp_val = (rdata >> sh) & 32'hFFFF;
        if (sext && exp_val >= 32'h8000) exp_val = exp_val | 32'hFFFF_0000;
      end
      default: exp_val = rdata;
    endcase
    exp_wen = !chk_err && !resp && (rd != 5'd0);

    exu_load_en        = 1'b1;
    exu_load_rd        = rd;
    exu_load_base_addr = base;
    exu_load_offset    = off;
    exu_load_sext      = sext;
    exu_load_size      = size;
    hready             = 1'b1;
    hresp              = 1'b0;
    @(posedge hclk); #1;
    if (!hold) begin
      exu_load_en        = 1'b0;
      exu_load_rd        = 5'($urandom);
      exu_load_base_addr = $urandom;
      exu_load_offset    = $urandom;
      exu_load_sext      = 1'($urandom);
      exu_load_size      = 2'($urandom);
    end

    if (chk_err) begin
      m_err = 1'b1;
      m_err_addr = ea;
      @(negedge hclk);
      check("cerr_htrans", 32'(htrans), 32'h0);
      check("cerr_busy",   32'(mau_load_busy), 32'h1);
      check("cerr_done",   32'(mau_load_done), 32'h1);
      check("cerr_err",    32'(mau_load_err), 32'h1);
      check("cerr_eaddr",  mau_load_err_addr, ea);
      check("cerr_wen",    32'(reg_wen), 32'h0);
      @(posedge hclk); #1;
    end else begin
      for (int i = 0; i <= aw; i++) begin
        hready = (i == aw);
        @(negedge hclk);
        check("addr_htrans", 32'(htrans), 32'h2);
        check("addr_haddr",  haddr, ea);
        check("addr_hsize",  32'(hsize), 32'(size) - 32'd1);
        check("addr_hwrite", 32'(hwrite), 32'h0);
        check("addr_busy",   32'(mau_load_busy), 32'h1);
        check("addr_done",   32'(mau_load_done), 32'h0);
        @(posedge hclk); #1;
      end
      for (int j = 0; j <= dw; j++) begin
        hready = (j == dw);
        hresp  = (j == dw) ? resp : 1'b0;
        hrdata = (j == dw) ? rdata : $urandom;
        @(negedge hclk);
        check("data_htrans", 32'(htrans), 32'h0);
        check("data_busy",   32'(mau_load_busy), 32'h1);
        check("data_done",   32'(mau_load_done), 32'h0);
        check("data_wen",    32'(reg_wen), 32'h0);
        @(posedge hclk); #1;
      end
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = $urandom;
      m_err = resp;
      if (resp) m_err_addr = ea;
      @(negedge hclk);
      check("wb_done",   32'(mau_load_done), 32'h1);
      check("wb_busy",   32'(mau_load_busy), 32'h1);
      check("wb_htrans", 32'(htrans), 32'h0);
      check("wb_wen",    32'(reg_wen), 32'(exp_wen));
      if (exp_wen) begin
        check("wb_waddr", 32'(reg_waddr), 32'(rd));
        check("wb_wdata", reg_wdata, exp_val);
      end
      check("wb_err",   32'(mau_load_err), 32'(m_err));
      check("wb_eaddr", mau_load_err_addr, m_err_addr);
      @(posedge hclk); #1;
    end

    // Engine must return to idle and must not re-accept a held request.
    for (int k = 0; k < ((idle_cyc < 1) ? 1 : idle_cyc); k++) begin
      @(negedge hclk);
      check("post_busy",   32'(mau_load_busy), 32'h0);
      check("post_done",   32'(mau_load_done), 32'h0);
      check("post_wen",    32'(reg_wen), 32'h0);
      check("post_htrans", 32'(htrans), 32'h0);
      @(posedge hclk); #1;
    end
    exu_load_en = 1'b0;
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] base;
    logic [31:0] off;

    hrst = 1'b1;
    exu_load_en = 1'b0;
    exu_load_rd = 5'd0;
    exu_load_base_addr = 32'h0;
    exu_load_offset = 32'h0;
    exu_load_sext = 1'b0;
    exu_load_size = 2'd0;
    hrdata = 32'h0;
    hready = 1'b1;
    hresp = 1'b0;
    m_err = 1'b0;
    m_err_addr = 32'h0;

    #12;
    check_reset_vals("rst");
    @(posedge hclk); #1;
    hrst = 1'b0;
    @(posedge hclk); #1;

    // Aligned word, no waits.
    run_load(5'd5, 32'h2000_0000, 32'h4, 1'b0, 2'd3, 0, 0, 32'h8765_4321, 1'b0, 1'b0, 1);
    check("t1_wdata", reg_wdata, 32'h8765_4321);

    // Signed and unsigned byte from lane 3 with a negative offset.
    run_load(5'd1, 32'h1000, 32'hFFFF_FFFF, 1'b1, 2'd1, 0, 0, 32'h8012_3456, 1'b0, 1'b0, 1);
    check("t2s_wdata", reg_wdata, 32'hFFFF_FF80);
    run_load(5'd1, 32'h1000, 32'hFFFF_FFFF, 1'b0, 2'd1, 0, 0, 32'h8012_3456, 1'b0, 1'b0, 1);
    check("t2u_wdata", reg_wdata, 32'h0000_0080);

    // Unsigned upper half with wait states in both phases.
    run_load(5'd3, 32'h100, 32'h2, 1'b0, 2'd2, 2, 3, 32'hBEEF_1234, 1'b0, 1'b0, 1);
    check("t3_wdata", reg_wdata, 32'h0000_BEEF);

    // Misaligned word, then a good load clears the sticky error.
    run_load(5'd4, 32'h100, 32'h3, 1'b0, 2'd3, 0, 0, 32'h0, 1'b0, 1'b0, 2);
    check("t4_err_sticky", 32'(mau_load_err), 32'h1);
    check("t4_eaddr", mau_load_err_addr, 32'h103);
    run_load(5'd4, 32'h100, 32'h4, 1'b0, 2'd3, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1);
    check("t4_err_clr", 32'(mau_load_err), 32'h0);

    // Bus error, then a good load to x0.
    run_load(5'd7, 32'h300, 32'h8, 1'b0, 2'd3, 1, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1);
    check("t5_eaddr", mau_load_err_addr, 32'h308);
    run_load(5'd0, 32'h400, 32'h0, 1'b0, 2'd3, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 1);

    // Request held high: executes exactly once.
    run_load(5'd9, 32'h500, 32'h1, 1'b1, 2'd1, 0, 0, 32'h0000_7F00, 1'b0, 1'b1, 9);

    // Reset in the data phase.
    exu_load_en = 1'b1;
    exu_load_rd = 5'd9;
    exu_load_base_addr = 32'h40;
    exu_load_offset = 32'h0;
    exu_load_size = 2'd3;
    hready = 1'b1;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hready = 1'b0;
    exu_load_en = 1'b0;
    @(negedge hclk);
    check("rstm_busy", 32'(mau_load_busy), 32'h1);
    #1;
    hrst = 1'b1;
    #1;
    check_reset_vals("rstm");
    m_err = 1'b0;
    m_err_addr = 32'h0;
    @(posedge hclk); #1;
    hrst = 1'b0;
    hready = 1'b1;
    hrdata = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge hclk);
      check("rstm_wen",  32'(reg_wen), 32'h0);
      check("rstm_done", 32'(mau_load_done), 32'h0);
      check("rstm_busy", 32'(mau_load_busy), 32'h0);
      @(posedge hclk); #1;
    end

    // Randomized loads.
    for (int n = 0; n < 200; n++) begin
      base = $urandom;
      off  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        base[1:0] = 2'b00;
        off[1:0]  = 2'b00;
      end
      run_load(5'($urandom), base, off, 1'($urandom), 2'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, ($urandom_range(0, 7) == 0),
               1'($urandom), int'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
